// File: rtl/pipe_skid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for valid/ready stream utilities:
//                skid buffer state encoding, depth constant and a helper
//                that maps a state to its buffered-entry count.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Number of entries a skid buffer can hold (output reg + skid reg).
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Explicit-width state constants for plain logic state registers.
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_BUSY  = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    // Entries held in each state. The encoding is chosen so the mapping is
    // the identity, but callers should not rely on that.
    function automatic logic [1:0] state_count(input logic [1:0] st);
        logic [1:0] cnt;
        cnt = 2'd0;
        case (st)
            c_ST_EMPTY: cnt = 2'd0;
            c_ST_BUSY:  cnt = 2'd1;
            c_ST_FULL:  cnt = 2'd2;
            default:    cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_if
//  Description : Stream bundle around a skid buffer.
//                Upstream   : data_i, valid_i  -> buffer ; ready_o -> source
//                Downstream : data_o, valid_o  -> sink   ; ready_i -> buffer
//                Status     : count_o (buffered entries, 0..2)
//                master = environment driving both stream sides,
//                slave  = the buffer itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_skid_if
    import pipe_pkg::*;
#(
    parameter int DATA_SIZE = 1
);
    logic [DATA_SIZE-1:0] data_i;
    logic                 valid_i;
    logic                 ready_o;
    logic [DATA_SIZE-1:0] data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic [1:0]           count_o;

    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, count_o
    );

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid
//  Description : Two-entry skid buffer for valid/ready streams. Both the
//                forward path (data/valid) and the backward path (ready) are
//                flop outputs, so downstream ready never reaches upstream
//                ready combinationally. Synchronous flush empties the buffer.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous reset, ACTIVE HIGH (legacy name)
//                flush  - synchronous flush, highest priority
//                bus    - pipe_skid_if.slave stream bundle
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_skid
    import pipe_pkg::*;
#(
    parameter int DATA_SIZE = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       flush,
    pipe_skid_if.slave      bus
);

    logic [1:0]           r_state;
    logic [DATA_SIZE-1:0] r_out;
    logic [DATA_SIZE-1:0] r_skid;
    logic                 r_valid;
    logic                 r_ready;

    logic w_in_fire;
    logic w_out_fire;

    assign w_in_fire  = bus.valid_i & r_ready;
    assign w_out_fire = r_valid & bus.ready_i;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= c_ST_EMPTY;
            r_out   <= '0;
            r_skid  <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else if (flush) begin
            // Any beat offered this cycle is dropped; an out_fire this cycle
            // has already been taken by the sink.
            r_state <= c_ST_EMPTY;
            r_out   <= '0;
            r_skid  <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_out   <= bus.data_i;
                        r_valid <= 1'b1;
                        r_state <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (w_in_fire && !w_out_fire) begin
                        // Beat accepted while the sink stalled: park it in
                        // the skid register and close the upstream door.
                        r_skid  <= bus.data_i;
                        r_ready <= 1'b0;
                        r_state <= c_ST_FULL;
                    end else if (!w_in_fire && w_out_fire) begin
                        r_valid <= 1'b0;
                        r_state <= c_ST_EMPTY;
                    end else if (w_in_fire && w_out_fire) begin
                        r_out <= bus.data_i;
                    end
                end
                c_ST_FULL: begin
                    if (w_out_fire) begin
                        r_out   <= r_skid;
                        r_ready <= 1'b1;
                        r_state <= c_ST_BUSY;
                    end
                end
                default: begin
                    r_state <= c_ST_EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.data_o  = r_out;
    assign bus.valid_o = r_valid;
    assign bus.ready_o = r_ready;
    assign bus.count_o = state_count(r_state);

`ifndef SYNTHESIS
    // Remembers that valid_o was high with no consumption and no flush, so
    // the following edge can confirm valid_o did not drop.
    logic r_chk_hold;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_chk_hold <= 1'b0;
        end else begin
            r_chk_hold <= r_valid & ~bus.ready_i & ~flush;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_valid_hold : assert (!r_chk_hold || r_valid);
            a_count_max  : assert (state_count(r_state) <= 2'(SKID_DEPTH) && r_state != 2'd3);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid
//  Description : Self-checking bench for pipe_skid. Accepted beats are queued
//                as expected output and compared when the sink takes a beat;
//                occupancy, valid and ready are checked against queue depth.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_skid;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    pipe_skid_if #(.DATA_SIZE(DW)) bus ();

    pipe_skid #(.DATA_SIZE(DW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp_v);
        end
    endtask

    // One clock cycle: drive at negedge, score fires before posedge,
    // then check occupancy-derived outputs after the edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic fl);
        logic [DW-1:0] exp_d;
        logic          rdy_before;
        @(negedge clk);
        rdy_before  = bus.ready_o;
        bus.valid_i = v;
        bus.data_i  = d;
        bus.ready_i = r;
        flush       = fl;
        #1;
        chk("ready_no_comb_path", 32'(bus.ready_o), 32'(rdy_before));
        if (bus.valid_o && r) begin
            if (sb.size() == 0) begin
                chk("spurious_beat_valid", 32'(bus.valid_o), 32'd0);
            end else begin
                exp_d = sb.pop_front();
                chk("sb_data", 32'(bus.data_o), 32'(exp_d));
            end
        end
        if (fl) begin
            sb.delete();
        end else if (v && bus.ready_o) begin
            sb.push_back(d);
        end
        @(posedge clk);
        #1;
        chk("count", 32'(bus.count_o), 32'(sb.size()));
        chk("valid", 32'(bus.valid_o), 32'(sb.size() != 0));
        chk("ready", 32'(bus.ready_o), 32'(sb.size() < 2));
    endtask

    initial begin
        rst_n       = 1'b1;
        flush       = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.ready_i = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(bus.valid_o), 32'd0);
        chk("reset_ready", 32'(bus.ready_o), 32'd1);
        chk("reset_count", 32'(bus.count_o), 32'd0);
        chk("reset_data",  32'(bus.data_o),  32'd0);
        @(negedge clk);
        rst_n = 1'b0;

        // ---------------- stream at full rate ----------------
        cyc(1'b1, 8'h01, 1'b1, 1'b0);
        chk("stream_d1", 32'(bus.data_o), 32'h01);
        cyc(1'b1, 8'h02, 1'b1, 1'b0);
        chk("stream_d2", 32'(bus.data_o), 32'h02);
        cyc(1'b1, 8'h03, 1'b1, 1'b0);
        chk("stream_d3", 32'(bus.data_o), 32'h03);
        chk("stream_cnt", 32'(bus.count_o), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // ---------------- backpressure into skid ----------------
        cyc(1'b1, 8'h0A, 1'b0, 1'b0);
        cyc(1'b1, 8'h0B, 1'b0, 1'b0);
        chk("bp_ready", 32'(bus.ready_o), 32'd0);
        chk("bp_data",  32'(bus.data_o),  32'h0A);
        chk("bp_count", 32'(bus.count_o), 32'd2);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);           // refused: ready_o is low
        chk("bp_hold", 32'(bus.data_o), 32'h0A);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_skid_out", 32'(bus.data_o), 32'h0B);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_empty", 32'(bus.valid_o), 32'd0);

        // ---------------- simultaneous in/out in BUSY ----------------
        cyc(1'b1, 8'h05, 1'b0, 1'b0);
        cyc(1'b1, 8'h06, 1'b1, 1'b0);
        chk("sim_data",  32'(bus.data_o),  32'h06);
        chk("sim_count", 32'(bus.count_o), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // ---------------- flush while FULL ----------------
        cyc(1'b1, 8'h07, 1'b0, 1'b0);
        cyc(1'b1, 8'h08, 1'b0, 1'b0);
        cyc(1'b1, 8'h09, 1'b0, 1'b1);
        chk("flush_valid", 32'(bus.valid_o), 32'd0);
        chk("flush_ready", 32'(bus.ready_o), 32'd1);
        chk("flush_count", 32'(bus.count_o), 32'd0);
        chk("flush_data",  32'(bus.data_o),  32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // ---------------- async reset while FULL ----------------
        cyc(1'b1, 8'h71, 1'b0, 1'b0);
        cyc(1'b1, 8'h72, 1'b0, 1'b0);
        @(negedge clk);
        bus.valid_i = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.valid_o), 32'd0);
        chk("arst_ready", 32'(bus.ready_o), 32'd1);
        chk("arst_count", 32'(bus.count_o), 32'd0);
        chk("arst_data",  32'(bus.data_o),  32'd0);
        sb.delete();
        #1;
        rst_n = 1'b0;

        // ---------------- random valid/ready ----------------
        for (int i = 0; i < 10000; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 63) == 0));
        end

        // ---------------- drain ----------------
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        chk("drain_valid", 32'(bus.valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
